// File: rtl/traffic_pkg.sv
// Shared phase encodings and field widths for the traffic-light controller and display decoder.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package traffic_pkg;

    localparam int STATE_W = 2;
    localparam int COUNT_W = 4;
    localparam int ROW_W   = 3;

    localparam logic [STATE_W-1:0] ST_GO   = 2'd0;
    localparam logic [STATE_W-1:0] ST_WARN = 2'd1;
    localparam logic [STATE_W-1:0] ST_STOP = 2'd2;

    function automatic logic [STATE_W-1:0] next_phase(input logic [STATE_W-1:0] cur);
        case (cur)
            ST_GO:   next_phase = ST_WARN;
            ST_WARN: next_phase = ST_STOP;
            default: next_phase = ST_GO;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Free-running divider emitting a one-cycle tick every DIV clocks.
// Latency: tick is combinational from the counter; first tick DIV cycles after reset.
// Backpressure: none, never stalls.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Light-phase FSM with per-phase seconds countdown, dot-matrix row scan and pedestrian latch.
// Latency: all outputs registered, change one cycle after the triggering tick or edge.
// Backpressure: none; pause freezes phase/countdown only, scan keeps running.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int           SEC_DIV  = 50_000_000,
    parameter int           SCAN_DIV = 50_000,
    parameter logic [3:0]   T_GO     = 4'd9,
    parameter logic [3:0]   T_WARN   = 4'd3,
    parameter logic [3:0]   T_STOP   = 4'd12,
    parameter logic [3:0]   T_PED    = 4'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic               ped_req,
    output logic [STATE_W-1:0] state,
    output logic [COUNT_W-1:0] count_down,
    output logic [ROW_W-1:0]   row_cnt,
    output logic               ped_pend
);

    logic sec_tick;
    logic scan_tick;
    logic ped_q;

    tick_gen #(.DIV(SEC_DIV)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (sec_tick)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (scan_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_STOP;
            count_down <= T_STOP;
            row_cnt    <= '0;
            ped_pend   <= 1'b0;
            ped_q      <= 1'b0;
        end else begin
            ped_q <= ped_req;

            if (scan_tick) begin
                row_cnt <= row_cnt + 1'b1;
            end

            // A pending request is consumed on any STOP cycle, capped or not.
            if (ped_pend && state == ST_STOP) begin
                ped_pend <= 1'b0;
            end else if (ped_req && !ped_q) begin
                ped_pend <= 1'b1;
            end

            if (state > ST_STOP) begin
                state      <= ST_STOP;
                count_down <= T_STOP;
            end else if (ped_pend && state == ST_STOP && count_down > T_PED) begin
                count_down <= T_PED;
            end else if (sec_tick && !pause) begin
                if (count_down != '0) begin
                    count_down <= count_down - 1'b1;
                end else begin
                    state <= next_phase(state);
                    case (state)
                        ST_GO:   count_down <= T_WARN;
                        ST_WARN: count_down <= T_STOP;
                        default: count_down <= T_GO;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs, a monitor pops and compares.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] state;
    logic [3:0] count_down;
    logic [2:0] row_cnt;
    logic       ped_pend;

    traffic_light_ctrl #(
        .SEC_DIV  (4),
        .SCAN_DIV (2),
        .T_GO     (4'd3),
        .T_WARN   (4'd1),
        .T_STOP   (4'd4),
        .T_PED    (4'd1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .ped_req    (ped_req),
        .state      (state),
        .count_down (count_down),
        .row_cnt    (row_cnt),
        .ped_pend   (ped_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [3:0] cd;
        logic [2:0] row;
        logic       pend;
        bit         chk_st;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   n      = 0;
    int   tag_id = 0;

    // Hand-computed free-run (state, count_down) per elapsed second from reset.
    int seq_st[11] = '{2, 2, 2, 2, 2, 0, 0, 0, 0, 1, 1};
    int seq_cd[11] = '{4, 3, 2, 1, 0, 3, 2, 1, 0, 1, 0};

    task automatic push(input int es, input int ec, input int er, input bit ep, input bit cs);
        exp_t e;
        e.st     = es[1:0];
        e.cd     = ec[3:0];
        e.row    = er[2:0];
        e.pend   = ep;
        e.chk_st = cs;
        e.tag    = tag_id;
        tag_id++;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit ps, input bit pr, input int es, input int ec, input bit ep,
                       input bit cs = 1'b1);
        pause   = ps;
        ped_req = pr;
        @(posedge clk);
        #1;
        n++;
        push(es, ec, (n / 2) % 8, ep, cs);
    endtask

    task automatic seg(input int cnt, input bit ps, input bit pr, input int es, input int ec,
                       input bit ep);
        for (int i = 0; i < cnt; i++) cyc(ps, pr, es, ec, ep);
    endtask

    task automatic chk_rst();
        @(posedge clk);
        #1;
        push(2, 4, 0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ((!e.chk_st || state === e.st) && count_down === e.cd &&
                    row_cnt === e.row && ped_pend === e.pend) begin
                    passed++;
                end else begin
                    $display("FAIL step%0d: got st=%0d cd=%0d row=%0d pend=%0b, expected st=%0d cd=%0d row=%0d pend=%0b (st checked=%0b)",
                             e.tag, state, count_down, row_cnt, ped_pend,
                             e.st, e.cd, e.row, e.pend, e.chk_st);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int waited;
        repeat (3) chk_rst();
        @(negedge clk);
        #2;
        rst = 1'b0;
        n = 0;

        // Free run through a full phase cycle, row wrap included.
        for (int k = 1; k <= 43; k++) cyc(1'b0, 1'b0, seq_st[k / 4], seq_cd[k / 4], 1'b0);
        seg(4, 1'b0, 1'b0, 2, 4, 1'b0);

        // Pause across three seconds, then resume without a burst.
        seg(12, 1'b1, 1'b0, 2, 4, 1'b0);
        cyc(1'b0, 1'b0, 2, 3, 1'b0);

        // Held-high request at STOP cd=3: latched once, capped next cycle.
        cyc(1'b0, 1'b1, 2, 3, 1'b1);
        cyc(1'b0, 1'b1, 2, 1, 1'b0);
        cyc(1'b0, 1'b1, 2, 1, 1'b0);
        cyc(1'b0, 1'b1, 2, 0, 1'b0);
        cyc(1'b0, 1'b1, 2, 0, 1'b0);
        seg(2, 1'b0, 1'b0, 2, 0, 1'b0);

        // Request during GO stays pending through WARN, served on STOP entry.
        cyc(1'b0, 1'b0, 0, 3, 1'b0);
        cyc(1'b0, 1'b1, 0, 3, 1'b1);
        seg(2, 1'b0, 1'b0, 0, 3, 1'b1);
        seg(4, 1'b0, 1'b0, 0, 2, 1'b1);
        seg(4, 1'b0, 1'b0, 0, 1, 1'b1);
        seg(4, 1'b0, 1'b0, 0, 0, 1'b1);
        seg(4, 1'b0, 1'b0, 1, 1, 1'b1);
        seg(4, 1'b0, 1'b0, 1, 0, 1'b1);
        cyc(1'b0, 1'b0, 2, 4, 1'b1);
        cyc(1'b0, 1'b0, 2, 1, 1'b0);

        // Request at STOP cd=1: set then cleared, countdown untouched.
        cyc(1'b0, 1'b1, 2, 1, 1'b1);
        cyc(1'b0, 1'b0, 2, 1, 1'b0);
        cyc(1'b0, 1'b0, 2, 0, 1'b0);
        cyc(1'b1, 1'b0, 2, 0, 1'b0);

        // Illegal state 3 upset recovers to STOP with a fresh countdown.
        @(negedge clk);
        #2;
        force dut.state = 2'd3;
        cyc(1'b1, 1'b0, 2, 4, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        release dut.state;
        cyc(1'b1, 1'b0, 2, 4, 1'b0, 1'b0);
        seg(2, 1'b1, 1'b0, 2, 4, 1'b0);

        // Serving is not blocked by pause.
        cyc(1'b1, 1'b1, 2, 4, 1'b1);
        cyc(1'b1, 1'b0, 2, 1, 1'b0);
        cyc(1'b1, 1'b0, 2, 1, 1'b0);
        seg(3, 1'b0, 1'b0, 2, 1, 1'b0);
        seg(4, 1'b0, 1'b0, 2, 0, 1'b0);
        seg(4, 1'b0, 1'b0, 0, 3, 1'b0);
        seg(4, 1'b0, 1'b0, 0, 2, 1'b0);
        seg(4, 1'b0, 1'b0, 0, 1, 1'b0);
        seg(4, 1'b0, 1'b0, 0, 0, 1'b0);
        seg(4, 1'b0, 1'b0, 1, 1, 1'b0);
        seg(4, 1'b0, 1'b0, 1, 0, 1'b0);
        seg(3, 1'b0, 1'b0, 2, 4, 1'b0);

        // Serve coincides with a second tick: cap wins, no extra decrement.
        cyc(1'b0, 1'b1, 2, 4, 1'b1);
        cyc(1'b0, 1'b0, 2, 1, 1'b0);
        seg(3, 1'b0, 1'b0, 2, 1, 1'b0);
        seg(4, 1'b0, 1'b0, 2, 0, 1'b0);

        // Asynchronous reset mid-cycle, held with inputs active.
        @(negedge clk);
        #2;
        push(2, 4, 0, 1'b0, 1'b1);
        rst = 1'b1;
        pause = 1'b1;
        ped_req = 1'b1;
        repeat (3) chk_rst();
        ped_req = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        n = 0;
        seg(3, 1'b0, 1'b0, 2, 4, 1'b0);
        seg(4, 1'b0, 1'b0, 2, 3, 1'b0);
        cyc(1'b0, 1'b0, 2, 2, 1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
